// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch-side handshakes of ifu_fetch: RAM request/response, EXU redirect, IDU issue
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

interface ifu_fetch_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int INST_WIDTH = `INST_WIDTH
);
  logic                  o_ram_req_valid;
  logic                  i_ram_req_ready;
  logic [ADDR_WIDTH-1:0] o_ram_req_addr;
  logic                  i_ram_rsp_valid;
  logic [INST_WIDTH-1:0] i_ram_rsp_inst;
  logic                  i_jmp_en;
  logic [ADDR_WIDTH-1:0] i_jmp_pc;
  logic                  o_idu_valid;
  logic                  i_idu_ready;
  logic [INST_WIDTH-1:0] o_idu_inst;
  logic [ADDR_WIDTH-1:0] o_idu_pc;

  modport master (
    output o_ram_req_valid, o_ram_req_addr, o_idu_valid, o_idu_inst, o_idu_pc,
    input  i_ram_req_ready, i_ram_rsp_valid, i_ram_rsp_inst, i_jmp_en, i_jmp_pc, i_idu_ready
  );

  modport slave (
    input  o_ram_req_valid, o_ram_req_addr, o_idu_valid, o_idu_inst, o_idu_pc,
    output i_ram_req_ready, i_ram_rsp_valid, i_ram_rsp_inst, i_jmp_en, i_jmp_pc, i_idu_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC, one-outstanding RAM fetch, instruction FIFO, redirect
// Optional performance counters are built when IFU_PERF_EN is defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module ifu_fetch #(
  parameter int          ADDR_WIDTH = `ADDR_WIDTH,
  parameter int          INST_WIDTH = `INST_WIDTH,
  parameter logic [31:0] RST_PC     = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
`ifdef IFU_PERF_EN
  output logic [31:0] o_ifu_perf_fetch_cnt,
  output logic [31:0] o_ifu_perf_stall_cnt,
`endif
  ifu_fetch_if.master bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] RST_PC_A = ADDR_WIDTH'(RST_PC);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_d   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic req_valid, req_fire, push, pop, flush, fifo_empty;

  assign fifo_empty = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    flush       = 1'b0;

    // A slot is reserved at issue time, so a response can always be pushed.
    req_valid = (state_q == S_REQ) && (cnt_q < CNT_W'(FIFO_DEPTH)) && !bus.i_jmp_en;
    req_fire  = req_valid && bus.i_ram_req_ready;
    pop       = !fifo_empty && bus.i_idu_ready;

    if (bus.i_jmp_en) begin
      pc_d  = bus.i_jmp_pc & ~ADDR_WIDTH'(3);
      flush = 1'b1;
      if ((state_q == S_WAIT) && !bus.i_ram_rsp_valid) begin
        drop_d = 1'b1;
      end else begin
        drop_d  = 1'b0;
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + ADDR_WIDTH'(4);
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.i_ram_rsp_valid) begin
            if (drop_q) drop_d = 1'b0;
            else        push   = 1'b1;
            state_d = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]   = req_pc_q;
        fifo_inst_d[wr_ptr_q] = bus.i_ram_rsp_inst;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RST_PC_A;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
    end
  end

  assign bus.o_ram_req_valid = req_valid;
  assign bus.o_ram_req_addr  = req_valid ? pc_q : '0;
  assign bus.o_idu_valid     = !fifo_empty;
  assign bus.o_idu_inst      = fifo_empty ? '0 : fifo_inst_q[rd_ptr_q];
  assign bus.o_idu_pc        = fifo_empty ? '0 : fifo_pc_q[rd_ptr_q];

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, pop};
    stall_cnt_d = stall_cnt_q + {31'd0, fifo_empty && (state_q != S_IDLE)};
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_ifu_perf_fetch_cnt = fetch_cnt_q;
  assign o_ifu_perf_stall_cnt = stall_cnt_q;
`endif

  // IDLE is tolerated: a fetch issued just before reset may still answer in the first cycle after it.
  a_rsp_only_when_waiting: assert property (@(posedge i_sys_clk) disable iff (i_sys_rst)
    bus.i_ram_rsp_valid |-> (state_q == S_WAIT || state_q == S_IDLE));
endmodule
